// File: rtl/irq_ctrl.sv
// Single-level interrupt controller: synchronised edge-triggered sources, pending/mask
// registers, and an IDLE/ASSERT/SERVICE handshake with the CPU (ack, then EOI).
module irq_ctrl #(
    parameter int         NSRC        = 4,
    parameter logic [3:0] SPURIOUS_ID = 4'hF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src,
    input  logic            ack,
    input  logic [1:0]      addr,
    input  logic            wr,
    input  logic [15:0]     wdata,
    output logic [15:0]     rdata,
    output logic            irq
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_t;

    logic [NSRC-1:0] sync1_q, sync2_q, prev_q;
    logic [NSRC-1:0] pend_q, pend_d, mask_q, mask_d;
    logic [NSRC-1:0] edges, active, ackSel, pendClr;
    logic [1:0]      warm_q;
    logic            causeValid_q;
    logic [3:0]      causeId_q, ackId;
    logic            ackHit, takeAck, pendWr, maskWr, eoiWr;
    state_t          state_q;
    logic            irq_q;

    assign edges   = sync2_q & ~prev_q;
    assign active  = pend_q & mask_q;
    assign pendWr  = wr && (addr == 2'd0);
    assign maskWr  = wr && (addr == 2'd1);
    assign eoiWr   = wr && (addr == 2'd3) && (state_q == SERVICE);
    assign takeAck = ack && (state_q == ASSERT);
    assign irq     = irq_q;

    always_comb begin
        ackId  = '0;
        ackSel = '0;
        ackHit = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                ackId     = 4'(i);
                ackSel    = '0;
                ackSel[i] = 1'b1;
                ackHit    = 1'b1;
            end
        end
    end

    // A new edge on a bit always beats a software or ack clear of that bit.
    always_comb begin
        pendClr = '0;
        if (pendWr) begin
            pendClr = wdata[NSRC-1:0];
        end
        if (takeAck) begin
            pendClr = pendClr | ackSel;
        end
        pend_d = (pend_q & ~pendClr) | edges;
        mask_d = maskWr ? wdata[NSRC-1:0] : mask_q;
    end

    // Until the synchroniser has filled after reset, prev follows what sync2 is about to
    // hold, so a line already high at reset release is not mistaken for a rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            warm_q  <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
        end else begin
            sync1_q <= src;
            sync2_q <= sync1_q;
            prev_q  <= warm_q[1] ? sync2_q : sync1_q;
            warm_q  <= {warm_q[0], 1'b1};
            pend_q  <= pend_d;
            mask_q  <= mask_d;
        end
    end

    // Withdrawal looks at next-cycle PEND/MASK so a clear lands in IDLE before a later ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            irq_q        <= 1'b0;
            causeValid_q <= 1'b0;
            causeId_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|active) begin
                        state_q <= ASSERT;
                        irq_q   <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (ack) begin
                        state_q      <= SERVICE;
                        irq_q        <= 1'b0;
                        causeValid_q <= ackHit;
                        causeId_q    <= ackHit ? ackId : SPURIOUS_ID;
                    end else if (!(|(pend_d & mask_d))) begin
                        state_q <= IDLE;
                        irq_q   <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (eoiWr) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        case (addr)
            2'd0:    rdata = 16'(pend_q);
            2'd1:    rdata = 16'(mask_q);
            2'd2:    rdata = {causeValid_q, 11'b0, causeId_q};
            default: rdata = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: hand-computed register and irq values after each
// scripted sequence of source edges, acks, register writes and resets.
module tb_irq_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  src;
    logic        ack;
    logic [1:0]  addr;
    logic        wr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        irq;

    int total = 0;
    int bad   = 0;

    irq_ctrl #(.NSRC(4), .SPURIOUS_ID(4'hF)) dut (
        .clk   (clk),
        .rst   (rst),
        .src   (src),
        .ack   (ack),
        .addr  (addr),
        .wr    (wr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkReg(input string tag, input logic [1:0] a, input logic [15:0] exp);
        addr = a;
        #1;
        checkOutput(tag, rdata, exp);
    endtask

    task automatic checkIrq(input string tag, input logic exp);
        checkOutput(tag, {15'b0, irq}, {15'b0, exp});
    endtask

    task automatic writeReg(input logic [1:0] a, input logic [15:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        step(1);
        wr    = 1'b0;
    endtask

    task automatic pulseAck();
        ack = 1'b1;
        step(1);
        ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; src = '0; ack = 1'b0; addr = '0; wr = 1'b0; wdata = '0;
        step(2);
        checkIrq("rst_irq", 1'b0);
        checkReg("rst_pend", 2'd0, 16'h0000);
        checkReg("rst_mask", 2'd1, 16'h0000);
        checkReg("rst_cause", 2'd2, 16'h0000);
        rst = 1'b0;
        step(3);

        // Single source latency and ack
        writeReg(2'd1, 16'h0001);
        checkReg("mask_rd", 2'd1, 16'h0001);
        src = 4'b0001;
        step(1);
        checkReg("lat_pend_k", 2'd0, 16'h0000);
        step(1);
        checkReg("lat_pend_k1", 2'd0, 16'h0000);
        step(1);
        checkReg("lat_pend_k2", 2'd0, 16'h0001);
        checkIrq("lat_irq_k2", 1'b0);
        step(1);
        checkIrq("lat_irq_k3", 1'b1);
        pulseAck();
        checkIrq("ack_irq", 1'b0);
        checkReg("ack_cause", 2'd2, 16'h8000);
        checkReg("ack_pend", 2'd0, 16'h0000);
        checkReg("eoi_rd", 2'd3, 16'h0000);
        writeReg(2'd3, 16'h0000);
        src = 4'b0000;

        // Priority between two simultaneous sources
        writeReg(2'd1, 16'hFFFF);
        checkReg("mask_unimpl", 2'd1, 16'h000F);
        src = 4'b1010;
        step(3);
        checkReg("prio_pend", 2'd0, 16'h000A);
        step(1);
        checkIrq("prio_irq", 1'b1);
        pulseAck();
        checkReg("prio_cause1", 2'd2, 16'h8001);
        checkReg("prio_pend1", 2'd0, 16'h0008);
        checkIrq("prio_irq_svc", 1'b0);
        writeReg(2'd3, 16'h1234);
        checkIrq("prio_irq_eoi", 1'b0);
        step(1);
        checkIrq("prio_irq_re", 1'b1);
        pulseAck();
        checkReg("prio_cause3", 2'd2, 16'h8003);
        checkReg("prio_pend3", 2'd0, 16'h0000);
        writeReg(2'd3, 16'h0000);
        src = 4'b0000;

        // Masked source, late unmask, withdrawal by PEND clear
        writeReg(2'd1, 16'h0000);
        src = 4'b0100;
        step(3);
        checkReg("mask_pend", 2'd0, 16'h0004);
        step(2);
        checkIrq("mask_irq0", 1'b0);
        writeReg(2'd1, 16'h0004);
        checkIrq("unmask_irq_w", 1'b0);
        step(1);
        checkIrq("unmask_irq", 1'b1);
        writeReg(2'd0, 16'h0004);
        checkIrq("withdraw_irq", 1'b0);
        checkReg("withdraw_pend", 2'd0, 16'h0000);
        src = 4'b0000;

        // Clear and ack in the same cycle, then clear before ack
        writeReg(2'd1, 16'h000F);
        src = 4'b0001;
        step(4);
        checkReg("same_pend", 2'd0, 16'h0001);
        checkIrq("same_irq", 1'b1);
        addr = 2'd0; wdata = 16'h0001; wr = 1'b1; ack = 1'b1;
        step(1);
        wr = 1'b0; ack = 1'b0;
        checkReg("same_cause", 2'd2, 16'h8000);
        checkReg("same_pend_after", 2'd0, 16'h0000);
        checkIrq("same_irq_after", 1'b0);
        writeReg(2'd3, 16'h0000);
        src = 4'b0000;
        step(3);
        src = 4'b0001;
        step(4);
        checkIrq("early_irq", 1'b1);
        writeReg(2'd0, 16'h0001);
        checkIrq("early_withdraw", 1'b0);
        pulseAck();
        checkReg("idle_ack_cause", 2'd2, 16'h8000);
        checkIrq("idle_ack_irq", 1'b0);
        src = 4'b0000;

        // Request withdrawn on the very edge it was raised: ack is spurious
        src = 4'b0010;
        step(3);
        writeReg(2'd0, 16'h0002);
        checkIrq("spur_irq", 1'b1);
        checkReg("spur_pend", 2'd0, 16'h0000);
        pulseAck();
        checkReg("spur_cause", 2'd2, 16'h000F);
        checkIrq("spur_irq_after", 1'b0);
        writeReg(2'd3, 16'h0000);
        src = 4'b0000;

        // Edge and ack while in SERVICE
        step(3);
        src = 4'b0010;
        step(4);
        checkIrq("svc_irq", 1'b1);
        pulseAck();
        checkReg("svc_cause", 2'd2, 16'h8001);
        src = 4'b0011;
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        step(2);
        checkReg("svc_pend", 2'd0, 16'h0001);
        checkReg("svc_cause_keep", 2'd2, 16'h8001);
        checkIrq("svc_irq_low", 1'b0);
        writeReg(2'd3, 16'h0000);
        checkIrq("svc_eoi_irq", 1'b0);
        step(1);
        checkIrq("svc_reassert", 1'b1);
        pulseAck();
        checkReg("svc_cause0", 2'd2, 16'h8000);
        writeReg(2'd3, 16'h0000);

        // Reset in SERVICE with pending bits, sources held high across release
        src = 4'b0111;
        step(4);
        checkIrq("rs_irq", 1'b1);
        pulseAck();
        checkReg("rs_cause", 2'd2, 16'h8002);
        src = 4'b0100;
        step(3);
        src = 4'b0111;
        step(3);
        checkReg("rs_pend", 2'd0, 16'h0003);
        rst = 1'b1;
        step(1);
        checkReg("rs_pend0", 2'd0, 16'h0000);
        checkReg("rs_mask0", 2'd1, 16'h0000);
        checkReg("rs_cause0", 2'd2, 16'h0000);
        checkIrq("rs_irq0", 1'b0);
        step(1);
        rst = 1'b0;
        step(6);
        checkReg("rel_pend", 2'd0, 16'h0000);
        writeReg(2'd1, 16'h000F);
        step(2);
        checkIrq("rel_irq", 1'b0);
        checkReg("rel_pend2", 2'd0, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NSRC, default 4, meaning number of interrupt sources (1..8).
REQ-002 Parameter SPURIOUS_ID, default 4'hF, meaning CAUSE.id value for an ack with nothing pending.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 src  input  NSRC  asynchronous level interrupt lines; rising edge requests service.
REQ-006 ack  input  1  one-cycle pulse from CPU when it accepts the interrupt (decode-phase call push).
REQ-007 addr  input  2  register select: 0 PEND, 1 MASK, 2 CAUSE, 3 EOI.
REQ-008 wr  input  1  register write strobe, one cycle.
REQ-009 wdata  input  16  write data.
REQ-010 rdata  output  16  combinational read of the register selected by addr; unused upper bits 0.
REQ-011 irq  output  1  registered interrupt request to CPU.

Function
REQ-012 Each src bit passes a 2-flop synchronizer, then a registered rising-edge detector (sync2 & ~prev).
REQ-013 A detected edge sets PEND[i]; a rising src edge becomes PEND-visible after exactly 3 clk edges from the first edge sampling it high.
REQ-014 PEND write (addr 0): write-1-to-clear per bit; a set and a clear of the same bit in one cycle leaves the bit set.
REQ-015 MASK (addr 1): read/write, NSRC bits, 1 = enabled; write takes effect next cycle.
REQ-016 CAUSE (addr 2): read-only; bit 15 = valid, bits 3:0 = id of the source taken at the last ack.
REQ-017 EOI (addr 3): write of any value ends service; reads return 0.
REQ-018 State machine, states IDLE, ASSERT, SERVICE; irq = 1 only in ASSERT.
REQ-019 IDLE -> ASSERT when |(PEND & MASK); otherwise IDLE.
REQ-020 ASSERT -> SERVICE on ack; ASSERT -> IDLE without ack when PEND & MASK becomes 0 (request withdrawn).
REQ-021 On ack in ASSERT: select lowest index i with PEND[i] & MASK[i], using values before any same-cycle write; CAUSE <= {valid=1, id=i}; clear PEND[i] (a same-cycle new edge on i keeps it set).
REQ-022 If PEND & MASK is 0 in the ack cycle, CAUSE <= {valid=0, id=SPURIOUS_ID}; still go to SERVICE.
REQ-023 SERVICE -> IDLE on EOI write; no nesting; edges arriving in SERVICE only accumulate in PEND.
REQ-024 ack in IDLE or SERVICE is ignored: no state, CAUSE or PEND change.
REQ-025 EOI write outside SERVICE is ignored.
REQ-026 Latency: PEND&MASK nonzero in cycle n -> irq high in cycle n+1; ack in cycle m -> irq low in cycle m+1.
REQ-027 Writes to unimplemented bits are ignored; source bits >= NSRC read 0.

Reset
REQ-028 On rst: state IDLE, irq 0, PEND 0, MASK 0, CAUSE 0, synchronizer and edge-detect flops 0.
REQ-029 rst wins over every simultaneous event, including ack, wr and src edges; a src already high at reset release produces no edge.
REQ-030 Reset mid-ASSERT or mid-SERVICE returns to IDLE with no residual request.

Verification
REQ-031 MASK=1, src[0] 0->1 at edge k -> PEND=1 after edge k+2, irq=1 after edge k+3; ack -> CAUSE=16'h8000, PEND=0, irq=0 next cycle.
REQ-032 MASK=4'hF, src[3] and src[1] rise same cycle -> ack gives CAUSE id 1; EOI -> irq reasserts; second ack gives id 3.
REQ-033 MASK=0, src[2] rises -> PEND=4'h4, irq stays 0; write MASK=4'h4 -> irq 1 two cycles after the write; write PEND=4'h4 before ack -> irq drops (withdraw to IDLE).
REQ-034 ASSERT with PEND=4'h1, same cycle: PEND write 4'h1 and ack -> CAUSE id 0, valid=1; same sequence with PEND cleared one cycle earlier, then ack -> ack ignored (IDLE).
REQ-035 In SERVICE, src[0] edge and ack pulse -> PEND[0]=1, CAUSE unchanged, irq 0 until EOI write.
REQ-036 rst asserted in SERVICE with PEND=4'h3 -> next cycle all registers 0, irq 0; src held high across reset release -> no PEND set.
